mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported synchronous memory between the CPU instruction-fetch port and data port.
//  Sits between cpu and memory in computer, replacing the dual-bus memory hookup.
//  Arbitrates round-robin, issues one access at a time and returns read data to the winning requester.
//  Data stores are one-cycle posted writes.
// PARAMETERS
//  AW         16  address width (bits)
//  DW         16  data width (bits)
//  RD_LAT     1   memory read latency in cycles, >=1 (mem_rdata valid RD_LAT cycles after mem_en&!mem_we)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  i_req      in   1   fetch request; held with i_addr until i_gnt
//  i_addr     in   AW  fetch address
//  i_gnt      out  1   fetch accepted this cycle
//  i_rvalid   out  1   i_rdata valid (1-cycle pulse)
//  i_rdata    out  DW  fetched word
//  d_req      in   1   data request; held with d_we/d_addr/d_wdata until d_gnt
//  d_we       in   1   1=write, 0=read
//  d_addr     in   AW  data address
//  d_wdata    in   DW  write data
//  d_gnt      out  1   data request accepted this cycle
//  d_rvalid   out  1   d_rdata valid (1-cycle pulse, reads only)
//  d_rdata    out  DW  read word
//  mem_en     out  1   memory access strobe
//  mem_we     out  1   memory write enable (qualified by mem_en)
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data
// BEHAVIOUR
//  - Reset: state=IDLE, last_owner=D (fetch wins first tie), lat_cnt=0, all gnt/rvalid/mem_en/mem_we=0.
//    mem_addr/mem_wdata/rdata=0.
//  - FSM IDLE/RD_WAIT. A grant may issue in IDLE, or in RD_WAIT on the cycle lat_cnt==RD_LAT (the return cycle).
//  - Grant: combinational in the grant cycle. Winner = sole requester; if both, owner != last_owner.
//    Exactly one gnt high; mem_en=1 and mem_* = winner's fields in the same cycle; last_owner <= winner.
//  - Write grant (d_we=1): completes in that cycle, no rvalid, state stays/returns IDLE.
//    Back-to-back writes every cycle are allowed.
//  - Read grant: state->RD_WAIT, lat_cnt<=1, rd_owner<=winner.
//    lat_cnt increments each cycle; when lat_cnt==RD_LAT, rd_owner's rvalid=1 and rdata=mem_rdata (combinational pass).
//    Then state->IDLE, unless a new read is granted the same cycle (stays RD_WAIT, lat_cnt<=1).
//  - Throughput: one read per RD_LAT cycles; no request is starved (round-robin bound = 1 access).
//  - Non-grant cycles: mem_en=0; mem_we=0 always when mem_en=0.
//  - Requester deasserting req before gnt is a protocol violation; behaviour undefined (assertion in sim).
//  - Reset mid-read: pending read dropped, no rvalid issued after rst_n release.
//  - lat_cnt width = $clog2(RD_LAT+1); no wrap possible.
// CONFIGURATION
//  MEM_ARB_PERF_EN defined:
//    adds outputs perf_i_stall[15:0] and perf_d_stall[15:0].
//    Each counts cycles its req=1 && gnt=0; saturates at 16'hFFFF; cleared by rst_n.
//  Undefined: ports and counters absent; arbitration identical.
// STRUCTURE
//  Package mem_arb_pkg: typedef enum {ARB_IDLE, ARB_RD_WAIT} arb_state_t;
//    typedef enum logic {OWN_I=0, OWN_D=1} arb_owner_t; localparam RESET_LAST_OWNER = OWN_D.
//  One sub-module: mem_arb_rr2 (pure 2-way round-robin pick: req[1:0], last -> gnt[1:0]).
//  FSM, latency counter and return mux stay in the top.
// TESTING
//  1 Reset, RD_LAT=1: i_req=1 addr 16'h0010, mem[0x10]=16'hBEEF ->
//    i_gnt cycle 0, i_rvalid cycle 1 with i_rdata=16'hBEEF.
//  2 i_req and d_req (read 0x0020) same cycle after reset ->
//    fetch granted first; data granted on fetch's rvalid cycle; d_rvalid next cycle.
//  3 d_req write x4 (0x30..0x33, data 1..4), i_req idle -> d_gnt 4 consecutive cycles; readback returns 1..4.
//  4 RD_LAT=3, continuous fetch -> i_gnt every 3rd cycle, i_rvalid 3 cycles after each gnt.
//  5 Both requesting continuously -> grants alternate I,D,I,D; no requester waits >1 access.
//  6 rst_n low during RD_WAIT (RD_LAT=3) -> no rvalid after release; outputs at reset values;
//    perf counters (MEM_ARB_PERF_EN) read 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    // Fetch wins the first tie after reset
    localparam arb_owner_t RESET_LAST_OWNER = OWN_D;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin pick: bit 0 = fetch, bit 1 = data; a tie goes to the non-last owner.
module mem_arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0]  req,
    input  arb_owner_t  last,
    output logic [1:0]  gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == OWN_D) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between the fetch and data ports.
// Optional MEM_ARB_PERF_EN adds saturating per-port stall counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
`ifdef MEM_ARB_PERF_EN
    output logic [15:0]   perf_i_stall,
    output logic [15:0]   perf_d_stall,
`endif
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

    arb_state_t        state_q, state_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    arb_owner_t        rd_owner_q, rd_owner_d;
    arb_owner_t        last_owner_q, last_owner_d;
    logic [1:0]        rr_gnt;
    logic              rd_return;
    logic              grant_ok;

    mem_arb_rr2 u_rr2 (
        .req  ({d_req, i_req}),
        .last (last_owner_q),
        .gnt  (rr_gnt)
    );

    // The return cycle of a read doubles as the next grant slot
    assign rd_return = (state_q == ARB_RD_WAIT) && (lat_cnt_q == LAT_W'(RD_LAT));
    assign grant_ok  = (state_q == ARB_IDLE) || rd_return;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            lat_cnt_q    <= '0;
            rd_owner_q   <= OWN_I;
            last_owner_q <= RESET_LAST_OWNER;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            rd_owner_q   <= rd_owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        rd_owner_d   = rd_owner_q;
        last_owner_d = last_owner_q;
        i_gnt        = 1'b0;
        d_gnt        = 1'b0;
        i_rvalid     = 1'b0;
        d_rvalid     = 1'b0;
        i_rdata      = '0;
        d_rdata      = '0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        if (state_q == ARB_RD_WAIT) begin
            if (rd_return) begin
                state_d   = ARB_IDLE;
                lat_cnt_d = '0;
                if (rd_owner_q == OWN_I) begin
                    i_rvalid = 1'b1;
                    i_rdata  = mem_rdata;
                end else begin
                    d_rvalid = 1'b1;
                    d_rdata  = mem_rdata;
                end
            end else begin
                lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
        end

        if (grant_ok && rr_gnt[0]) begin
            i_gnt        = 1'b1;
            mem_en       = 1'b1;
            mem_addr     = i_addr;
            last_owner_d = OWN_I;
            rd_owner_d   = OWN_I;
            state_d      = ARB_RD_WAIT;
            lat_cnt_d    = LAT_W'(1);
        end else if (grant_ok && rr_gnt[1]) begin
            d_gnt        = 1'b1;
            mem_en       = 1'b1;
            mem_we       = d_we;
            mem_addr     = d_addr;
            mem_wdata    = d_we ? d_wdata : '0;
            last_owner_d = OWN_D;
            // Writes are posted and finish in the grant cycle
            if (!d_we) begin
                rd_owner_d = OWN_D;
                state_d    = ARB_RD_WAIT;
                lat_cnt_d  = LAT_W'(1);
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    // Stall cycles per port, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_i_stall <= '0;
            perf_d_stall <= '0;
        end else begin
            if (i_req && !i_gnt && (perf_i_stall != 16'hFFFF))
                perf_i_stall <= perf_i_stall + 16'd1;
            if (d_req && !d_gnt && (perf_d_stall != 16'hFFFF))
                perf_d_stall <= perf_d_stall + 16'd1;
        end
    end
`endif

    // Requests must stay up until granted
    a_i_hold: assert property (@(posedge clk) disable iff (!rst_n) (i_req && !i_gnt) |=> i_req);
    a_d_hold: assert property (@(posedge clk) disable iff (!rst_n) (d_req && !d_gnt) |=> d_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: RD_LAT=1 vector table plus RD_LAT=3 hand sequences.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;

    typedef logic [69:0] obs_t;

    typedef struct packed {
        logic        rst;
        logic        ireq;
        logic [15:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [15:0] daddr;
        logic [15:0] dwd;
        obs_t        exp;
    } vec_t;

    // DUT with RD_LAT=1
    logic        i1_req, i1_gnt, i1_rvalid, d1_req, d1_we, d1_gnt, d1_rvalid;
    logic [15:0] i1_addr, i1_rdata, d1_addr, d1_wdata, d1_rdata;
    logic        m1_en, m1_we;
    logic [15:0] m1_addr, m1_wdata, m1_rdata;
    // DUT with RD_LAT=3
    logic        i3_req, i3_gnt, i3_rvalid, d3_req, d3_we, d3_gnt, d3_rvalid;
    logic [15:0] i3_addr, i3_rdata, d3_addr, d3_wdata, d3_rdata;
    logic        m3_en, m3_we;
    logic [15:0] m3_addr, m3_wdata, m3_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] p1_i, p1_d, p3_i, p3_d;
`endif

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i1_req), .i_addr(i1_addr), .i_gnt(i1_gnt), .i_rvalid(i1_rvalid), .i_rdata(i1_rdata),
        .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata),
        .d_gnt(d1_gnt), .d_rvalid(d1_rvalid), .d_rdata(d1_rdata),
        .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
`ifdef MEM_ARB_PERF_EN
        .perf_i_stall(p1_i), .perf_d_stall(p1_d),
`endif
        .mem_rdata(m1_rdata)
    );

    mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i3_req), .i_addr(i3_addr), .i_gnt(i3_gnt), .i_rvalid(i3_rvalid), .i_rdata(i3_rdata),
        .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
        .d_gnt(d3_gnt), .d_rvalid(d3_rvalid), .d_rdata(d3_rdata),
        .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
`ifdef MEM_ARB_PERF_EN
        .perf_i_stall(p3_i), .perf_d_stall(p3_d),
`endif
        .mem_rdata(m3_rdata)
    );

    // Memory models: synchronous, read data RD_LAT cycles after the address
    logic [15:0] mem1 [0:255];
    logic [15:0] mem3 [0:255];
    logic [15:0] rd1, p0, p1, p2;

    always @(posedge clk) begin
        if (m1_en && m1_we) mem1[m1_addr[7:0]] <= m1_wdata;
        rd1 <= mem1[m1_addr[7:0]];
        if (m3_en && m3_we) mem3[m3_addr[7:0]] <= m3_wdata;
        p0 <= mem3[m3_addr[7:0]];
        p1 <= p0;
        p2 <= p1;
    end
    assign m1_rdata = rd1;
    assign m3_rdata = p2;

    obs_t obs1, obs3;
    assign obs1 = {i1_gnt, i1_rvalid, i1_rdata, d1_gnt, d1_rvalid, d1_rdata, m1_en, m1_we, m1_addr, m1_wdata};
    assign obs3 = {i3_gnt, i3_rvalid, i3_rdata, d3_gnt, d3_rvalid, d3_rdata, m3_en, m3_we, m3_addr, m3_wdata};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t ep(input logic ig, input logic iv, input logic [15:0] ird,
                                input logic dg, input logic dv, input logic [15:0] drd,
                                input logic en, input logic we, input logic [15:0] ad,
                                input logic [15:0] wd);
        return {ig, iv, ird, dg, dv, drd, en, we, ad, wd};
    endfunction

    function automatic vec_t mk(input logic rst, input logic ir, input logic [15:0] ia,
                                input logic dr, input logic dw, input logic [15:0] da,
                                input logic [15:0] dd, input obs_t e);
        vec_t v;
        v.rst = rst; v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwe = dw;
        v.daddr = da; v.dwd = dd; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    vec_t vecs [24];

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        {i1_req, d1_req, d1_we, i3_req, d3_req, d3_we} = '0;
        {i1_addr, d1_addr, d1_wdata, i3_addr, d3_addr, d3_wdata} = '0;
        for (int k = 0; k < 256; k++) begin
            mem1[k] = 16'h0;
            mem3[k] = 16'h0;
        end
        mem1[8'h10] = 16'hBEEF; mem1[8'h20] = 16'hCAFE;
        mem1[8'h40] = 16'h1234; mem1[8'h41] = 16'h5678;
        mem1[8'h50] = 16'hAAAA; mem1[8'h51] = 16'h5555;
        for (int k = 0; k < 5; k++) mem3[8'h70 + k] = 16'hA000 + 16'(k);

        //        rst ireq iaddr  dreq dwe daddr  dwd      ig iv ird      dg dv drd      en we addr   wd
        vecs[0]  = mk(0, 1, 'h10, 0, 0, 'h00, 'h00, ep(1, 0, 'h0000,  0, 0, 'h0000,  1, 0, 'h10, 'h00));
        vecs[1]  = mk(0, 0, 'h00, 0, 0, 'h00, 'h00, ep(0, 1, 'hBEEF,  0, 0, 'h0000,  0, 0, 'h00, 'h00));
        vecs[2]  = mk(1, 1, 'h10, 1, 0, 'h20, 'h00, ep(1, 0, 'h0000,  0, 0, 'h0000,  1, 0, 'h10, 'h00));
        vecs[3]  = mk(0, 0, 'h00, 1, 0, 'h20, 'h00, ep(0, 1, 'hBEEF,  1, 0, 'h0000,  1, 0, 'h20, 'h00));
        vecs[4]  = mk(0, 0, 'h00, 0, 0, 'h00, 'h00, ep(0, 0, 'h0000,  0, 1, 'hCAFE,  0, 0, 'h00, 'h00));
        vecs[5]  = mk(0, 0, 'h00, 1, 1, 'h30, 'h01, ep(0, 0, 'h0000,  1, 0, 'h0000,  1, 1, 'h30, 'h01));
        vecs[6]  = mk(0, 0, 'h00, 1, 1, 'h31, 'h02, ep(0, 0, 'h0000,  1, 0, 'h0000,  1, 1, 'h31, 'h02));
        vecs[7]  = mk(0, 0, 'h00, 1, 1, 'h32, 'h03, ep(0, 0, 'h0000,  1, 0, 'h0000,  1, 1, 'h32, 'h03));
        vecs[8]  = mk(0, 0, 'h00, 1, 1, 'h33, 'h04, ep(0, 0, 'h0000,  1, 0, 'h0000,  1, 1, 'h33, 'h04));
        vecs[9]  = mk(0, 0, 'h00, 1, 0, 'h30, 'h00, ep(0, 0, 'h0000,  1, 0, 'h0000,  1, 0, 'h30, 'h00));
        vecs[10] = mk(0, 0, 'h00, 1, 0, 'h31, 'h00, ep(0, 0, 'h0000,  1, 1, 'h0001,  1, 0, 'h31, 'h00));
        vecs[11] = mk(0, 0, 'h00, 1, 0, 'h32, 'h00, ep(0, 0, 'h0000,  1, 1, 'h0002,  1, 0, 'h32, 'h00));
        vecs[12] = mk(0, 0, 'h00, 1, 0, 'h33, 'h00, ep(0, 0, 'h0000,  1, 1, 'h0003,  1, 0, 'h33, 'h00));
        vecs[13] = mk(0, 0, 'h00, 0, 0, 'h00, 'h00, ep(0, 0, 'h0000,  0, 1, 'h0004,  0, 0, 'h00, 'h00));
        vecs[14] = mk(0, 1, 'h40, 1, 0, 'h50, 'h00, ep(1, 0, 'h0000,  0, 0, 'h0000,  1, 0, 'h40, 'h00));
        vecs[15] = mk(0, 1, 'h41, 1, 0, 'h50, 'h00, ep(0, 1, 'h1234,  1, 0, 'h0000,  1, 0, 'h50, 'h00));
        vecs[16] = mk(0, 1, 'h41, 1, 0, 'h51, 'h00, ep(1, 0, 'h0000,  0, 1, 'hAAAA,  1, 0, 'h41, 'h00));
        vecs[17] = mk(0, 0, 'h00, 1, 0, 'h51, 'h00, ep(0, 1, 'h5678,  1, 0, 'h0000,  1, 0, 'h51, 'h00));
        vecs[18] = mk(0, 0, 'h00, 0, 0, 'h00, 'h00, ep(0, 0, 'h0000,  0, 1, 'h5555,  0, 0, 'h00, 'h00));
        vecs[19] = mk(0, 1, 'h10, 1, 1, 'h60, 'h77, ep(1, 0, 'h0000,  0, 0, 'h0000,  1, 0, 'h10, 'h00));
        vecs[20] = mk(0, 0, 'h00, 1, 1, 'h60, 'h77, ep(0, 1, 'hBEEF,  1, 0, 'h0000,  1, 1, 'h60, 'h77));
        vecs[21] = mk(0, 0, 'h00, 0, 0, 'h00, 'h00, ep(0, 0, 'h0000,  0, 0, 'h0000,  0, 0, 'h00, 'h00));
        vecs[22] = mk(0, 0, 'h00, 1, 0, 'h60, 'h00, ep(0, 0, 'h0000,  1, 0, 'h0000,  1, 0, 'h60, 'h00));
        vecs[23] = mk(0, 0, 'h00, 0, 0, 'h00, 'h00, ep(0, 0, 'h0000,  0, 1, 'h0077,  0, 0, 'h00, 'h00));

        // Outputs while held in reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_dut1", obs1, '0);
        check("reset_dut3", obs3, '0);
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 24; i++) begin
            if (vecs[i].rst) pulse_reset();
            i1_req   = vecs[i].ireq;
            i1_addr  = vecs[i].iaddr;
            d1_req   = vecs[i].dreq;
            d1_we    = vecs[i].dwe;
            d1_addr  = vecs[i].daddr;
            d1_wdata = vecs[i].dwd;
            @(negedge clk);
            check($sformatf("vec%0d", i), obs1, vecs[i].exp);
            next_cycle();
        end

        // RD_LAT=3 continuous fetch: grant every 3rd cycle, data 3 cycles later
        for (int c = 0; c <= 12; c++) begin
            logic        eg, ev;
            logic [15:0] ed, ea;
            i3_req  = 1'b1;
            i3_addr = 16'h0070 + 16'(c / 3);
            eg = (c % 3 == 0);
            ev = (c >= 3) && (c % 3 == 0);
            ed = ev ? (16'hA000 + 16'(c / 3 - 1)) : 16'h0;
            ea = eg ? i3_addr : 16'h0;
            @(negedge clk);
            check($sformatf("lat3_c%0d", c), obs3, ep(eg, ev, ed, 0, 0, 16'h0, eg, 0, ea, 16'h0));
            next_cycle();
        end

        // Mid-read: reset lands while the last fetch is outstanding
        i3_req  = 1'b0;
        i3_addr = 16'h0;
        @(negedge clk);
        check("lat3_wait", obs3, '0);
`ifdef MEM_ARB_PERF_EN
        check16("perf_i_stall", p3_i, 16'd8);
        check16("perf_d_stall", p3_d, 16'd0);
`endif
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("in_reset_dut3", obs3, '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("post_reset_c%0d", c), obs3, '0);
`ifdef MEM_ARB_PERF_EN
            check16($sformatf("perf_clr_c%0d", c), p3_i, 16'd0);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
